// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack port between the fetch stage (master) and imem (slave).
// IMData is only meaningful in a cycle where IMReq and IMAck are both high.
interface if_fetch_stage_if #(
   parameter int PC_W = 10
);
   logic            IMReq;
   logic [PC_W-1:0] IMAddr;
   logic            IMAck;
   logic [31:0]     IMData;

   modport master (output IMReq, output IMAddr, input IMAck, input IMData);
   modport slave  (input IMReq, input IMAddr, output IMAck, output IMData);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage with single-entry output buffer: imem ack in cycle N -> ValidOut in N+1; IFIDWr=0 holds the
// buffer and suppresses new requests, never retracting one in flight. IF_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module if_fetch_stage #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     IFIDWr,
   input  logic                     RedirectValid,
   input  logic [PC_W-1:0]          RedirectPC,
   if_fetch_stage_if.master         imem,
   output logic [31:0]              InstructionOut,
   output logic [PC_W-1:0]          PCOut,
   output logic                     ValidOut,
   output logic                     FaultOut
);

   typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} stateT;

   stateT           state, nextState;
   logic [PC_W-1:0] pc, reqPc, bufPc, redirPc, addr;
   logic [31:0]     instBuf;
   logic            bufValid;
   logic            req, issue, load, consume, redir, pending, misalign, haltReq;

`ifdef IF_MISALIGN_TRAP_EN
   logic faultQ;

   assign redirPc  = RedirectPC;
   assign misalign = RedirectValid & (RedirectPC[1:0] != 2'b00);
   assign haltReq  = faultQ | misalign;
   assign FaultOut = faultQ;

   always_ff @(posedge clk) begin
      if (rst)
         faultQ <= 1'b0;
      else if (redir & misalign)
         faultQ <= 1'b1;
   end
`else
   assign redirPc  = RedirectPC & ~PC_W'(3);
   assign misalign = 1'b0;
   assign haltReq  = 1'b0;
   assign FaultOut = 1'b0;
`endif

   always_comb begin
      req  = 1'b0;
      addr = pc;
      unique case (state)
         REQ:        req = !bufValid | IFIDWr;
         WAIT, DROP: begin
            req  = 1'b1;
            addr = reqPc;
         end
         default:    req = 1'b0;
      endcase
   end

   assign issue   = (state == REQ) & req;
   assign redir   = RedirectValid & (state != HALT);
   // A request still unanswered at the end of this cycle must be drained through DROP.
   assign pending = req & !imem.IMAck;
   assign load    = req & imem.IMAck & !RedirectValid & ((state == REQ) | (state == WAIT));
   assign consume = bufValid & IFIDWr;

   always_comb begin
      nextState = state;
      unique case (state)
         REQ:  if (issue & !imem.IMAck) nextState = WAIT;
         WAIT: if (imem.IMAck) nextState = REQ;
         DROP: if (imem.IMAck) nextState = haltReq ? HALT : REQ;
         HALT: nextState = HALT;
      endcase
      if (redir)
         nextState = pending ? DROP : (haltReq ? HALT : REQ);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= REQ;
         pc       <= RESET_PC;
         reqPc    <= '0;
         instBuf  <= '0;
         bufPc    <= '0;
         bufValid <= 1'b0;
      end else begin
         state <= nextState;
         if (issue)
            reqPc <= pc;
         if (redir)
            pc <= redirPc;
         else if (issue)
            pc <= pc + PC_W'(4);
         if (load) begin
            instBuf <= imem.IMData;
            bufPc   <= (state == REQ) ? pc : reqPc;
         end
         if (redir)
            bufValid <= 1'b0;
         else if (load)
            bufValid <= 1'b1;
         else if (consume)
            bufValid <= 1'b0;
      end
   end

   assign imem.IMReq     = req;
   assign imem.IMAddr    = addr;
   assign InstructionOut = instBuf;
   assign PCOut          = bufPc;
   assign ValidOut       = bufValid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory returns {16'hC0DE, 6'b0, IMAddr} so the buffered word identifies its address.
module tb_if_fetch_stage;
   localparam int PC_W = 10;

   logic            clk;
   logic            rst;
   logic            IFIDWr;
   logic            RedirectValid;
   logic [PC_W-1:0] RedirectPC;
   logic [31:0]     InstructionOut;
   logic [PC_W-1:0] PCOut;
   logic            ValidOut;
   logic            FaultOut;

   int checks   = 0;
   int failures = 0;

   if_fetch_stage_if #(.PC_W(PC_W)) imem ();

   assign imem.IMData = {16'hC0DE, 6'd0, imem.IMAddr};

   if_fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .clk            (clk),
      .rst            (rst),
      .IFIDWr         (IFIDWr),
      .RedirectValid  (RedirectValid),
      .RedirectPC     (RedirectPC),
      .imem           (imem.master),
      .InstructionOut (InstructionOut),
      .PCOut          (PCOut),
      .ValidOut       (ValidOut),
      .FaultOut       (FaultOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      IFIDWr = 1'b1;
      RedirectValid = 1'b0;
      RedirectPC = '0;
      imem.IMAck = 1'b0;
      tick;
      tick;
      checkVal("rst_valid", 32'(ValidOut), 32'd0);
      checkVal("rst_pcout", 32'(PCOut), 32'h000);
      checkVal("rst_inst", InstructionOut, 32'h0);
      checkVal("rst_fault", 32'(FaultOut), 32'd0);

      // zero-wait streaming from RESET_PC
      rst = 1'b0;
      imem.IMAck = 1'b1;
      #1;
      checkVal("first_req", 32'(imem.IMReq), 32'd1);
      checkVal("first_addr", 32'(imem.IMAddr), 32'h000);
      tick;
      checkVal("s1_valid", 32'(ValidOut), 32'd1);
      checkVal("s1_pcout", 32'(PCOut), 32'h000);
      checkVal("s1_addr", 32'(imem.IMAddr), 32'h004);
      tick;
      checkVal("s2_pcout", 32'(PCOut), 32'h004);
      checkVal("s2_addr", 32'(imem.IMAddr), 32'h008);
      tick;
      checkVal("s3_pcout", 32'(PCOut), 32'h008);
      checkVal("s3_valid", 32'(ValidOut), 32'd1);

      // three-cycle stall holding PC 0x008
      IFIDWr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkVal("stall_req", 32'(imem.IMReq), 32'd0);
         checkVal("stall_pc", 32'(PCOut), 32'h008);
         checkVal("stall_inst", InstructionOut, 32'hC0DE0008);
         tick;
      end
      IFIDWr = 1'b1;
      #1;
      checkVal("unstall_req", 32'(imem.IMReq), 32'd1);
      checkVal("unstall_addr", 32'(imem.IMAddr), 32'h00C);
      tick;
      checkVal("unstall_pc", 32'(PCOut), 32'h00C);

      // two-cycle memory with IFIDWr dropped while waiting
      imem.IMAck = 1'b0;
      #1;
      checkVal("slow_addr0", 32'(imem.IMAddr), 32'h010);
      tick;
      checkVal("slow_bubble", 32'(ValidOut), 32'd0);
      IFIDWr = 1'b0;
      #1;
      checkVal("slow_hold_req", 32'(imem.IMReq), 32'd1);
      checkVal("slow_hold_addr", 32'(imem.IMAddr), 32'h010);
      tick;
      imem.IMAck = 1'b1;
      #1;
      checkVal("slow_ack_addr", 32'(imem.IMAddr), 32'h010);
      tick;
      checkVal("slow_valid", 32'(ValidOut), 32'd1);
      checkVal("slow_pc", 32'(PCOut), 32'h010);
      checkVal("slow_inst", InstructionOut, 32'hC0DE0010);
      checkVal("slow_noreq", 32'(imem.IMReq), 32'd0);

      // redirect while a request to 0x014 is outstanding
      IFIDWr = 1'b1;
      imem.IMAck = 1'b0;
      #1;
      checkVal("pend_addr", 32'(imem.IMAddr), 32'h014);
      tick;
      RedirectValid = 1'b1;
      RedirectPC = 10'h100;
      tick;
      RedirectValid = 1'b0;
      #1;
      checkVal("drop_valid", 32'(ValidOut), 32'd0);
      checkVal("drop_req", 32'(imem.IMReq), 32'd1);
      checkVal("drop_addr", 32'(imem.IMAddr), 32'h014);
      imem.IMAck = 1'b1;
      tick;
      checkVal("drop_discard", 32'(ValidOut), 32'd0);
      checkVal("tgt_addr", 32'(imem.IMAddr), 32'h100);
      tick;
      checkVal("tgt_pc", 32'(PCOut), 32'h100);
      checkVal("tgt_inst", InstructionOut, 32'hC0DE0100);
      checkVal("tgt_next", 32'(imem.IMAddr), 32'h104);

      // redirect on a zero-wait issue+ack, then PC wrap
      RedirectValid = 1'b1;
      RedirectPC = 10'h3F8;
      tick;
      RedirectValid = 1'b0;
      #1;
      checkVal("zw_redir_valid", 32'(ValidOut), 32'd0);
      checkVal("zw_redir_addr", 32'(imem.IMAddr), 32'h3F8);
      tick;
      checkVal("wrap_pc0", 32'(PCOut), 32'h3F8);
      tick;
      checkVal("wrap_pc1", 32'(PCOut), 32'h3FC);
      checkVal("wrap_addr", 32'(imem.IMAddr), 32'h000);
      tick;
      checkVal("wrap_pc2", 32'(PCOut), 32'h000);
      checkVal("wrap_valid", 32'(ValidOut), 32'd1);

      // back-to-back redirects: last target wins
      RedirectValid = 1'b1;
      RedirectPC = 10'h200;
      tick;
      RedirectPC = 10'h300;
      checkVal("b2b_valid", 32'(ValidOut), 32'd0);
      tick;
      RedirectValid = 1'b0;
      #1;
      checkVal("b2b_addr", 32'(imem.IMAddr), 32'h300);
      tick;
      checkVal("b2b_pc", 32'(PCOut), 32'h300);

      // misaligned redirect
      RedirectValid = 1'b1;
      RedirectPC = 10'h102;
      tick;
      RedirectValid = 1'b0;
      #1;
      checkVal("mis_valid", 32'(ValidOut), 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
      checkVal("mis_fault", 32'(FaultOut), 32'd1);
      checkVal("mis_req", 32'(imem.IMReq), 32'd0);
      RedirectValid = 1'b1;
      RedirectPC = 10'h080;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkVal("halt_req", 32'(imem.IMReq), 32'd0);
         checkVal("halt_fault", 32'(FaultOut), 32'd1);
         checkVal("halt_valid", 32'(ValidOut), 32'd0);
      end
      RedirectValid = 1'b0;
`else
      checkVal("mis_fault", 32'(FaultOut), 32'd0);
      checkVal("mis_req", 32'(imem.IMReq), 32'd1);
      checkVal("mis_addr", 32'(imem.IMAddr), 32'h100);
      tick;
      checkVal("mis_pc", 32'(PCOut), 32'h100);
`endif

      // reset while a request is outstanding
      imem.IMAck = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      imem.IMAck = 1'b1;
      #1;
      checkVal("rr_req", 32'(imem.IMReq), 32'd1);
      checkVal("rr_addr", 32'(imem.IMAddr), 32'h000);
      checkVal("rr_fault", 32'(FaultOut), 32'd0);
      checkVal("rr_valid", 32'(ValidOut), 32'd0);
      tick;
      checkVal("rr_pc", 32'(PCOut), 32'h000);
      checkVal("rr_valid2", 32'(ValidOut), 32'd1);
      checkVal("rr_next", 32'(imem.IMAddr), 32'h004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
